// File: rtl/idu_decode_stage_pkg.sv
// Shared decode definitions for the instruction-decode stage and its helpers.
//   - RV32I major opcode constants (OPC_LUI .. OPC_SYSTEM)
//   - funct7 values used by OP / OP-IMM decode
//   - alu_op encodings ({funct7[5], funct3} style)
//   - immediate-format enum consumed by idu_imm_gen
//   - packed struct of instruction-class flags
package idu_decode_stage_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // alu_op = {funct7[5], funct3}; ADD is also the default for non-ALU classes.
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SRA = 4'b1101;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_e;

    typedef struct packed {
        logic is_load;
        logic is_store;
        logic is_branch;
        logic is_jal;
        logic is_jalr;
        logic is_lui;
        logic is_auipc;
        logic is_system;
    } class_t;

endpackage

// File: rtl/idu_imm_gen.sv
// Immediate generator: builds the sign-extended immediate of an RV32I
// instruction word for the given format. Purely combinational.
// Ports:
//   inst  in  32      instruction word
//   fmt   in  enum    immediate format (IMM_NONE yields 0)
//   imm   out DATA_W  immediate, sign-extended to DATA_W
module idu_imm_gen
    import idu_decode_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [31:0]       inst,
    input  imm_fmt_e          fmt,
    output logic [DATA_W-1:0] imm
);

    logic [31:0] imm32;
    // Opcode bits never contribute to an immediate.
    logic        unused_bits;

    assign unused_bits = ^inst[6:0];

    always_comb begin
        imm32 = '0;
        case (fmt)
            IMM_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm32 = {inst[31:12], 12'b0};
            IMM_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = DATA_W'($signed(imm32));

endmodule

// File: rtl/idu_decode_stage.sv
// RV32I instruction-decode pipeline stage.
// Takes a fetched instruction + PC over a valid/ready handshake, decodes
// register fields, immediate, ALU op and class flags, and holds the result
// in a one-entry pipeline register offered to execute over valid/ready.
// A flush (redirect) drops both the held bundle and the incoming instruction.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   prev_valid / ready_o      upstream handshake
//   inst_i, pc_i              fetched instruction and its PC
//   flush                     redirect: discard held + incoming
//   valid_o / next_ready      downstream handshake
//   pc_o, inst_o              PC and raw word of the held instruction
//   rs1_o, rs2_o, rd_o        raw register index fields
//   imm_o, funct3_o, alu_op_o immediate, funct3, ALU operation
//   rwe_o                     register write enable (0 when rd = x0)
//   is_*_o                    instruction class flags
//   illegal_o                 only when IDU_ILLEGAL_TRAP_EN is defined:
//                             illegal encoding flag (forces rwe_o = 0)
module idu_decode_stage
    import idu_decode_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prev_valid,
    output logic              ready_o,
    input  logic [DATA_W-1:0] inst_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              flush,
    output logic              valid_o,
    input  logic              next_ready,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [4:0]        rd_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [2:0]        funct3_o,
    output logic [3:0]        alu_op_o,
    output logic              rwe_o,
    output logic              is_load_o,
    output logic              is_store_o,
    output logic              is_branch_o,
    output logic              is_jal_o,
    output logic              is_jalr_o,
    output logic              is_lui_o,
    output logic              is_auipc_o,
`ifdef IDU_ILLEGAL_TRAP_EN
    output logic              illegal_o,
`endif
    output logic              is_system_o
);

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [4:0]        rd;
    class_t            cls;
    imm_fmt_e          fmt;
    logic              wr_class;
    logic [3:0]        alu_op;
    logic              illegal;
    logic              rwe;
    logic [DATA_W-1:0] imm;
    logic              acc;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];
    assign rd     = inst_i[11:7];

    // The stage can take a new word whenever its register is empty or is
    // being emptied this cycle; deliberately independent of prev_valid.
    assign ready_o = !valid_o || next_ready;
    assign acc     = prev_valid && ready_o && !flush;

    always_comb begin
        cls      = '0;
        fmt      = IMM_NONE;
        wr_class = 1'b0;
        alu_op   = ALU_ADD;
        case (opcode)
            OPC_LUI: begin
                cls.is_lui = 1'b1;
                fmt        = IMM_U;
                wr_class   = 1'b1;
            end
            OPC_AUIPC: begin
                cls.is_auipc = 1'b1;
                fmt          = IMM_U;
                wr_class     = 1'b1;
            end
            OPC_JAL: begin
                cls.is_jal = 1'b1;
                fmt        = IMM_J;
                wr_class   = 1'b1;
            end
            OPC_JALR: begin
                cls.is_jalr = 1'b1;
                fmt         = IMM_I;
                wr_class    = 1'b1;
            end
            OPC_BRANCH: begin
                cls.is_branch = 1'b1;
                fmt           = IMM_B;
            end
            OPC_LOAD: begin
                cls.is_load = 1'b1;
                fmt         = IMM_I;
                wr_class    = 1'b1;
            end
            OPC_STORE: begin
                cls.is_store = 1'b1;
                fmt          = IMM_S;
            end
            OPC_OP_IMM: begin
                fmt      = IMM_I;
                wr_class = 1'b1;
                // Only SRAI carries the funct7[5] qualifier; for the other
                // OP-IMM ops those bits belong to the immediate.
                if (funct3 == 3'b101 && funct7 == F7_ALT) begin
                    alu_op = ALU_SRA;
                end else begin
                    alu_op = {1'b0, funct3};
                end
            end
            OPC_OP: begin
                wr_class = 1'b1;
                alu_op   = {funct7[5], funct3};
            end
            OPC_SYSTEM: begin
                cls.is_system = 1'b1;
                fmt           = IMM_I;
                // ECALL/EBREAK/xRET have funct3 = 0 and write nothing;
                // CSR instructions write rd.
                wr_class      = (funct3 != 3'b000);
            end
            default: begin
                // Unknown opcode: decodes as a NOP.
            end
        endcase
    end

`ifdef IDU_ILLEGAL_TRAP_EN
    logic known;

    assign known = (cls != '0) || opcode == OPC_OP_IMM || opcode == OPC_OP;

    always_comb begin
        illegal = !known || inst_i[1:0] != 2'b11 || inst_i == '0;
        if (opcode == OPC_OP) begin
            if (!(funct7 == F7_BASE ||
                  (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)))) begin
                illegal = 1'b1;
            end
        end
        if (opcode == OPC_OP_IMM) begin
            if (funct3 == 3'b001 && funct7 != F7_BASE) begin
                illegal = 1'b1;
            end
            if (funct3 == 3'b101 && funct7 != F7_BASE && funct7 != F7_ALT) begin
                illegal = 1'b1;
            end
        end
    end
`else
    assign illegal = 1'b0;
`endif

    assign rwe = wr_class && (rd != 5'd0) && !illegal;

    idu_imm_gen #(
        .DATA_W (DATA_W)
    ) u_imm_gen (
        .inst (inst_i[31:0]),
        .fmt  (fmt),
        .imm  (imm)
    );

    // Flush wins over everything. Data fields load only on accept, so a
    // stall (or an idle stage) holds them bit-exact.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o     <= 1'b0;
            pc_o        <= '0;
            inst_o      <= '0;
            rs1_o       <= '0;
            rs2_o       <= '0;
            rd_o        <= '0;
            imm_o       <= '0;
            funct3_o    <= '0;
            alu_op_o    <= '0;
            rwe_o       <= 1'b0;
            is_load_o   <= 1'b0;
            is_store_o  <= 1'b0;
            is_branch_o <= 1'b0;
            is_jal_o    <= 1'b0;
            is_jalr_o   <= 1'b0;
            is_lui_o    <= 1'b0;
            is_auipc_o  <= 1'b0;
            is_system_o <= 1'b0;
`ifdef IDU_ILLEGAL_TRAP_EN
            illegal_o   <= 1'b0;
`endif
        end else if (flush) begin
            valid_o <= 1'b0;
        end else if (acc) begin
            valid_o     <= 1'b1;
            pc_o        <= pc_i;
            inst_o      <= inst_i;
            rs1_o       <= inst_i[19:15];
            rs2_o       <= inst_i[24:20];
            rd_o        <= rd;
            imm_o       <= imm;
            funct3_o    <= funct3;
            alu_op_o    <= alu_op;
            rwe_o       <= rwe;
            is_load_o   <= cls.is_load;
            is_store_o  <= cls.is_store;
            is_branch_o <= cls.is_branch;
            is_jal_o    <= cls.is_jal;
            is_jalr_o   <= cls.is_jalr;
            is_lui_o    <= cls.is_lui;
            is_auipc_o  <= cls.is_auipc;
            is_system_o <= cls.is_system;
`ifdef IDU_ILLEGAL_TRAP_EN
            illegal_o   <= illegal;
`endif
        end else if (next_ready) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_idu_decode_stage.sv
// Scoreboard bench for idu_decode_stage: stimulus pushes the hand-decoded
// expected bundle when an instruction is accepted; a negedge monitor pops on
// every downstream transfer and checks stalled bundles hold unchanged.
module tb_idu_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] iw;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic        rwe;
        logic [7:0]  flags;   // {load,store,branch,jal,jalr,lui,auipc,system}
        logic        ill;
    } exp_t;

`ifdef IDU_ILLEGAL_TRAP_EN
    localparam logic ILL = 1'b1;
`else
    localparam logic ILL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prev_valid = 1'b0;
    logic        ready_o;
    logic [31:0] inst_in = '0;
    logic [31:0] pc_in = '0;
    logic        flush = 1'b0;
    logic        valid_o;
    logic        next_ready = 1'b0;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic [4:0]  rs1_o, rs2_o, rd_o;
    logic [31:0] imm_o;
    logic [2:0]  funct3_o;
    logic [3:0]  alu_op_o;
    logic        rwe_o;
    logic        is_load_o, is_store_o, is_branch_o, is_jal_o;
    logic        is_jalr_o, is_lui_o, is_auipc_o, is_system_o;
`ifdef IDU_ILLEGAL_TRAP_EN
    logic        illegal_o;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t mon_act, mon_exp;
    exp_t s_exp[4];
    logic [31:0] s_inst[4];

    always #5 clk = ~clk;

    idu_decode_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .prev_valid  (prev_valid),
        .ready_o     (ready_o),
        .inst_i      (inst_in),
        .pc_i        (pc_in),
        .flush       (flush),
        .valid_o     (valid_o),
        .next_ready  (next_ready),
        .pc_o        (pc_o),
        .inst_o      (inst_o),
        .rs1_o       (rs1_o),
        .rs2_o       (rs2_o),
        .rd_o        (rd_o),
        .imm_o       (imm_o),
        .funct3_o    (funct3_o),
        .alu_op_o    (alu_op_o),
        .rwe_o       (rwe_o),
        .is_load_o   (is_load_o),
        .is_store_o  (is_store_o),
        .is_branch_o (is_branch_o),
        .is_jal_o    (is_jal_o),
        .is_jalr_o   (is_jalr_o),
        .is_lui_o    (is_lui_o),
        .is_auipc_o  (is_auipc_o),
`ifdef IDU_ILLEGAL_TRAP_EN
        .illegal_o   (illegal_o),
`endif
        .is_system_o (is_system_o)
    );

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] iw,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [31:0] imm,
                                input logic [2:0] f3, input logic [3:0] alu,
                                input logic rwe, input logic [7:0] flags,
                                input logic ill);
        exp_t e;
        e.pc = pc; e.iw = iw; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
        e.imm = imm; e.f3 = f3; e.alu = alu; e.rwe = rwe; e.flags = flags; e.ill = ill;
        return e;
    endfunction

    function automatic exp_t actual();
        exp_t a;
        a.pc = pc_o; a.iw = inst_o; a.rs1 = rs1_o; a.rs2 = rs2_o; a.rd = rd_o;
        a.imm = imm_o; a.f3 = funct3_o; a.alu = alu_op_o; a.rwe = rwe_o;
        a.flags = {is_load_o, is_store_o, is_branch_o, is_jal_o,
                   is_jalr_o, is_lui_o, is_auipc_o, is_system_o};
`ifdef IDU_ILLEGAL_TRAP_EN
        a.ill = illegal_o;
`else
        a.ill = 1'b0;
`endif
        return a;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Drive one instruction; wait (bounded) for ready_o, then record the
    // expected bundle unless the word is flushed.
    task automatic send(input logic [31:0] iw, input logic [31:0] pc,
                        input logic fl, input exp_t e);
        int n = 0;
        prev_valid = 1'b1;
        inst_in    = iw;
        pc_in      = pc;
        flush      = fl;
        @(negedge clk);
        while (!ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: ready_o stuck 0 for pc %h", pc);
        end else if (!fl) begin
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    // Monitor: a transfer pops and compares; a stall compares against the
    // head to prove the bundle holds.
    always @(negedge clk) begin
        if (!rst && valid_o) begin
            mon_act = actual();
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bundle: got %h expected none", mon_act);
            end else if (next_ready) begin
                mon_exp = q.pop_front();
                chk("bundle", mon_act, mon_exp);
            end else begin
                chk("stall_hold", mon_act, q[0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        s_inst[0] = 32'h123452B7; // lui   x5,0x12345
        s_inst[1] = 32'h00001317; // auipc x6,1
        s_inst[2] = 32'h4030D413; // srai  x8,x1,3
        s_inst[3] = 32'h000280E7; // jalr  x1,0(x5)
        s_exp[0] = mk(32'h200, s_inst[0], 5'd8, 5'd3, 5'd5, 32'h12345000, 3'd5, 4'h0, 1'b1, 8'b0000_0100, 1'b0);
        s_exp[1] = mk(32'h204, s_inst[1], 5'd0, 5'd0, 5'd6, 32'h00001000, 3'd1, 4'h0, 1'b1, 8'b0000_0010, 1'b0);
        s_exp[2] = mk(32'h208, s_inst[2], 5'd1, 5'd3, 5'd8, 32'h00000403, 3'd5, 4'hD, 1'b1, 8'b0000_0000, 1'b0);
        s_exp[3] = mk(32'h20C, s_inst[3], 5'd5, 5'd0, 5'd1, 32'h00000000, 3'd0, 4'h0, 1'b1, 8'b0000_1000, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_valid", 128'(valid_o), 128'(0));
        chk("reset_outputs", actual(), '0);
        chk("reset_ready", 128'(ready_o), 128'(1));
        @(posedge clk); #1;

        // Single instructions with downstream always ready
        next_ready = 1'b1;
        send(32'h00500093, 32'h100, 1'b0,
             mk(32'h100, 32'h00500093, 5'd0, 5'd5, 5'd1, 32'h5, 3'd0, 4'h0, 1'b1, 8'b0, 1'b0));
        send(32'hFE20AE23, 32'h104, 1'b0,
             mk(32'h104, 32'hFE20AE23, 5'd1, 5'd2, 5'd28, 32'hFFFFFFFC, 3'd2, 4'h0, 1'b0, 8'b0100_0000, 1'b0));
        send(32'hFF9FF06F, 32'h108, 1'b0,
             mk(32'h108, 32'hFF9FF06F, 5'd31, 5'd25, 5'd0, 32'hFFFFFFF8, 3'd7, 4'h0, 1'b0, 8'b0001_0000, 1'b0));
        send(32'h402081B3, 32'h10C, 1'b0,
             mk(32'h10C, 32'h402081B3, 5'd1, 5'd2, 5'd3, 32'h0, 3'd0, 4'h8, 1'b1, 8'b0, 1'b0));

        // Stall the sub for three cycles while add waits upstream
        prev_valid = 1'b1;
        inst_in    = 32'h00208233; // add x4,x1,x2
        pc_in      = 32'h110;
        next_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_ready", 128'(ready_o), 128'(0));
            @(posedge clk); #1;
        end
        next_ready = 1'b1;
        send(32'h00208233, 32'h110, 1'b0,
             mk(32'h110, 32'h00208233, 5'd1, 5'd2, 5'd4, 32'h0, 3'd0, 4'h0, 1'b1, 8'b0, 1'b0));
        prev_valid = 1'b0;
        @(negedge clk);
        chk("no_bubble_valid", 128'(valid_o), 128'(1));
        @(posedge clk); #1;

        // Back-to-back stream: four consecutive valid cycles
        for (int k = 0; k < 4; k++) begin
            prev_valid = 1'b1;
            inst_in    = s_inst[k];
            pc_in      = 32'h200 + 32'(4 * k);
            @(negedge clk);
            if (k > 0) chk("stream_valid", 128'(valid_o), 128'(1));
            q.push_back(s_exp[k]);
            @(posedge clk); #1;
        end
        prev_valid = 1'b0;
        @(negedge clk);
        chk("stream_valid", 128'(valid_o), 128'(1));
        @(posedge clk); #1;

        // Flush drops the incoming lw
        send(32'h00500093, 32'h300, 1'b0,
             mk(32'h300, 32'h00500093, 5'd0, 5'd5, 5'd1, 32'h5, 3'd0, 4'h0, 1'b1, 8'b0, 1'b0));
        send(32'h0040A383, 32'h304, 1'b1, '0);
        prev_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", 128'(valid_o), 128'(0));
        @(posedge clk); #1;
        send(32'h00208463, 32'h308, 1'b0,
             mk(32'h308, 32'h00208463, 5'd1, 5'd2, 5'd8, 32'h8, 3'd0, 4'h0, 1'b0, 8'b0010_0000, 1'b0));

        // SYSTEM and illegal / unknown encodings
        send(32'h300024F3, 32'h400, 1'b0,
             mk(32'h400, 32'h300024F3, 5'd0, 5'd0, 5'd9, 32'h300, 3'd2, 4'h0, 1'b1, 8'b0000_0001, 1'b0));
        send(32'h00000073, 32'h404, 1'b0,
             mk(32'h404, 32'h00000073, 5'd0, 5'd0, 5'd0, 32'h0, 3'd0, 4'h0, 1'b0, 8'b0000_0001, 1'b0));
        send(32'h00000000, 32'h408, 1'b0,
             mk(32'h408, 32'h00000000, 5'd0, 5'd0, 5'd0, 32'h0, 3'd0, 4'h0, 1'b0, 8'b0, ILL));
        send(32'h0000008B, 32'h40C, 1'b0,
             mk(32'h40C, 32'h0000008B, 5'd0, 5'd0, 5'd1, 32'h0, 3'd0, 4'h0, 1'b0, 8'b0, ILL));
        prev_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset while a bundle is stalled
        next_ready = 1'b0;
        send(32'h300024F3, 32'h500, 1'b0,
             mk(32'h500, 32'h300024F3, 5'd0, 5'd0, 5'd9, 32'h300, 3'd2, 4'h0, 1'b1, 8'b0000_0001, 1'b0));
        prev_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        @(negedge clk);
        chk("midreset_valid", 128'(valid_o), 128'(0));
        chk("midreset_outputs", actual(), '0);
        next_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 128'(q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
